// File: rtl/banked_mem_pkg.sv
// Shared defaults, decode helpers and the in-flight response entry for the
// banked memory controller.
package banked_mem_pkg;

  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_BANK_WORDS = 1024;
  localparam int DEF_RD_LATENCY = 1;

  // Wide enough for the largest supported bank count (16).
  localparam int BANK_FIELD_W = 4;

  typedef struct packed {
    logic                    valid;
    logic [BANK_FIELD_W-1:0] bank;
    logic                    we;
    logic                    err;
  } inflight_t;

  // Number of byte-offset bits below the word index.
  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/banked_mem_ctrl_if.sv
// Requestor-side bus of the banked memory controller: per-port request,
// grant and response signals.
interface banked_mem_ctrl_if
  import banked_mem_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [NUM_PORTS-1:0]                   req_i;
  logic [NUM_PORTS-1:0]                   we_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [NUM_PORTS-1:0]                   gnt_o;
  logic [NUM_PORTS-1:0]                   rvalid_o;
  logic [NUM_PORTS-1:0]                   err_o;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o
  );

endinterface

// File: rtl/banked_mem_ctrl_rr_arbiter.sv
// Round-robin arbiter for one bank; the pointer moves past the winner only
// when a grant is actually issued.
module rr_arbiter
  import banked_mem_pkg::*;
#(
  parameter  int N  = DEF_NUM_PORTS,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] win_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        win_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (any_o) begin
      gnt_o[win_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) begin
      ptr_d = (win_o == IW'(N - 1)) ? '0 : win_o + 1'b1;
    end
  end

endmodule

// File: rtl/banked_mem_ctrl.sv
// Multi-port, multi-bank SRAM controller: per-bank round-robin arbitration,
// fixed-latency responses tracked per port in a short shift register.
module banked_mem_ctrl
  import banked_mem_pkg::*;
#(
  parameter  int NUM_PORTS  = DEF_NUM_PORTS,
  parameter  int NUM_BANKS  = DEF_NUM_BANKS,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BANK_WORDS = DEF_BANK_WORDS,
  parameter  int RD_LATENCY = DEF_RD_LATENCY,
  localparam int BE_W       = DATA_WIDTH / 8,
  localparam int WORD_W     = idx_width(BANK_WORDS),
  localparam int BANK_W     = idx_width(NUM_BANKS),
  localparam int PORT_W     = idx_width(NUM_PORTS),
  localparam int OFF        = off_bits(DATA_WIDTH),
  localparam int LOG_NB     = $clog2(NUM_BANKS),
  localparam int LOG_BW     = $clog2(BANK_WORDS),
  localparam int LIMIT_LSB  = OFF + LOG_NB + LOG_BW
) (
  input  logic                                 clk,
  input  logic                                 rst,
  banked_mem_ctrl_if.slave                     bus,
  output logic [NUM_BANKS-1:0]                 bank_req_o,
  output logic [NUM_BANKS-1:0]                 bank_we_o,
  output logic [NUM_BANKS-1:0][WORD_W-1:0]     bank_addr_o,
  output logic [NUM_BANKS-1:0][BE_W-1:0]       bank_be_o,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata_o,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata_i
);

  logic [NUM_PORTS-1:0][BANK_W-1:0] p_bank;
  logic [NUM_PORTS-1:0][WORD_W-1:0] p_word;
  logic [NUM_PORTS-1:0]             p_oor;

  logic [NUM_PORTS-1:0] breq [NUM_BANKS];
  logic [NUM_PORTS-1:0] bgnt [NUM_BANKS];
  logic [PORT_W-1:0]    bwin [NUM_BANKS];
  logic [NUM_BANKS-1:0] bany;

  logic [NUM_PORTS-1:0] gnt;

  inflight_t pipe_q [NUM_PORTS][RD_LATENCY];
  inflight_t pipe_d [NUM_PORTS][RD_LATENCY];
  inflight_t head   [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_bank[p] = BANK_W'((bus.addr_i[p] >> OFF) & ADDR_WIDTH'(NUM_BANKS - 1));
      p_word[p] = WORD_W'((bus.addr_i[p] >> (OFF + LOG_NB)) & ADDR_WIDTH'(BANK_WORDS - 1));
      p_oor[p]  = (bus.addr_i[p] >> LIMIT_LSB) != '0;
    end
  end

  // Out-of-range requests never reach a bank arbiter.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      breq[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        breq[b][p] = bus.req_i[p] & ~p_oor[p] & ~rst & (p_bank[p] == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    rr_arbiter #(
      .N (NUM_PORTS)
    ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (breq[b]),
      .gnt_o (bgnt[b]),
      .win_o (bwin[b]),
      .any_o (bany[b])
    );
  end

  always_comb begin
    gnt = bus.req_i & p_oor & {NUM_PORTS{~rst}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt = gnt | bgnt[b];
    end
  end

  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bany[b]) begin
        bank_req_o[b]   = 1'b1;
        bank_we_o[b]    = bus.we_i[bwin[b]];
        bank_addr_o[b]  = p_word[bwin[b]];
        bank_be_o[b]    = bus.be_i[bwin[b]];
        bank_wdata_o[b] = bus.wdata_i[bwin[b]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int k = 0; k < RD_LATENCY; k++) begin
          pipe_q[p][k] <= '0;
        end
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pipe_d[p][0] = '0;
      if (gnt[p]) begin
        pipe_d[p][0].valid = 1'b1;
        pipe_d[p][0].bank  = BANK_FIELD_W'(p_bank[p]);
        pipe_d[p][0].we    = bus.we_i[p];
        pipe_d[p][0].err   = p_oor[p];
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_d[p][k] = pipe_q[p][k-1];
      end
    end
  end

  // Bank read data lines up with the last pipeline stage by construction.
  always_comb begin
    bus.rvalid_o = '0;
    bus.err_o    = '0;
    bus.rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      head[p] = pipe_q[p][RD_LATENCY-1];
      if (head[p].valid && !rst) begin
        bus.rvalid_o[p] = 1'b1;
        bus.err_o[p]    = head[p].err;
        if (!head[p].we && !head[p].err) begin
          for (int b = 0; b < NUM_BANKS; b++) begin
            if (head[p].bank == BANK_FIELD_W'(b)) begin
              bus.rdata_o[p] = bank_rdata_i[b];
            end
          end
        end
      end
    end
  end

  assign bus.gnt_o = gnt;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Scoreboard bench: four controllers (RD_LATENCY 1..4) driven by identical
// stimulus, each backed by a behavioural SRAM of matching latency.
module tb_banked_mem_ctrl;
  import banked_mem_pkg::*;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int NL = 4;
  localparam logic [127:0] A5 = {16{8'hA5}};

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][15:0] be = '0;
  logic [1:0][127:0] wdata = '0;

  logic [1:0]        gnt_a    [NL];
  logic [1:0]        rvalid_a [NL];
  logic [1:0]        err_a    [NL];
  logic [1:0][127:0] rdata_a  [NL];
  logic [3:0]        breq_a   [NL];

  exp_t exp_q [NL][NP][$];
  logic [127:0] ref_mem [4096];
  int ptr [NB];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit chk_gnt = 0;
  logic [1:0] want_gnt = '0;
  bit chk_breq = 0;
  logic [3:0] want_breq = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    localparam int L = gi + 1;
    logic [NB-1:0]        b_req, b_we;
    logic [NB-1:0][9:0]   b_addr;
    logic [NB-1:0][15:0]  b_be;
    logic [NB-1:0][127:0] b_wdata, b_rdata;
    logic [127:0] mem [4096];
    logic [127:0] rpipe [NB][L];

    banked_mem_ctrl_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();
    assign bus.req_i   = req;
    assign bus.we_i    = we;
    assign bus.addr_i  = addr;
    assign bus.be_i    = be;
    assign bus.wdata_i = wdata;

    banked_mem_ctrl #(
      .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(32), .DATA_WIDTH(128),
      .BANK_WORDS(1024), .RD_LATENCY(L)
    ) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .bank_req_o(b_req), .bank_we_o(b_we), .bank_addr_o(b_addr),
      .bank_be_o(b_be), .bank_wdata_o(b_wdata), .bank_rdata_i(b_rdata)
    );

    assign gnt_a[gi]    = bus.gnt_o;
    assign rvalid_a[gi] = bus.rvalid_o;
    assign err_a[gi]    = bus.err_o;
    assign rdata_a[gi]  = bus.rdata_o;
    assign breq_a[gi]   = b_req;

    for (genvar b = 0; b < NB; b++) begin : g_rd
      assign b_rdata[b] = rpipe[b][L-1];
    end

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 4096; i++) mem[i] <= '0;
      end else begin
        for (int b = 0; b < NB; b++)
          if (b_req[b] && b_we[b])
            for (int i = 0; i < 16; i++)
              if (b_be[b][i]) mem[{2'(b), b_addr[b]}][8*i +: 8] <= b_wdata[b][8*i +: 8];
      end
    end

    always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
        rpipe[b][0] <= (b_req[b] && !b_we[b]) ? mem[{2'(b), b_addr[b]}] : '0;
        for (int k = 1; k < L; k++) rpipe[b][k] <= rpipe[b][k-1];
      end
    end
  end

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endfunction

  // Monitor: every response is popped and compared in the cycle it appears.
  always @(negedge clk) begin
    for (int li = 0; li < NL; li++) begin
      for (int p = 0; p < NP; p++) begin
        exp_t e;
        if (rvalid_a[li][p]) begin
          if (exp_q[li][p].size() == 0) begin
            chk($sformatf("unexpected_rvalid L%0d P%0d", li + 1, p), rvalid_a[li][p], 0);
          end else begin
            e = exp_q[li][p].pop_front();
            chk($sformatf("rsp_cycle L%0d P%0d", li + 1, p), cyc, e.due);
            chk($sformatf("rsp_err L%0d P%0d", li + 1, p), err_a[li][p], e.err);
            chk($sformatf("rsp_data L%0d P%0d", li + 1, p), rdata_a[li][p], e.data);
          end
        end else begin
          chk($sformatf("idle_err_rdata L%0d P%0d", li + 1, p), {err_a[li][p], rdata_a[li][p]}, 0);
          if (exp_q[li][p].size() != 0 && exp_q[li][p][0].due <= cyc) begin
            e = exp_q[li][p].pop_front();
            chk($sformatf("missing_rvalid L%0d P%0d due=%0d", li + 1, p, e.due), rvalid_a[li][p], 1);
          end
        end
      end
    end
  end

  task automatic model(input logic r);
    logic [1:0] eg;
    int bk [NP];
    int wd [NP];
    bit oor [NP];
    int w, pp, idx;
    exp_t e;
    eg = '0;
    if (r) begin
      for (int li = 0; li < NL; li++) begin
        chk($sformatf("rst_gnt L%0d", li + 1), gnt_a[li], 0);
        chk($sformatf("rst_bank_req L%0d", li + 1), breq_a[li], 0);
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        bk[p]  = int'(addr[p][5:4]);
        wd[p]  = int'(addr[p][15:6]);
        oor[p] = (addr[p][31:16] != 16'h0);
        if (req[p] && oor[p]) eg[p] = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        w = -1;
        for (int k = 0; k < NP; k++) begin
          pp = (ptr[b] + k) % NP;
          if (w < 0 && req[pp] && !oor[pp] && bk[pp] == b) w = pp;
        end
        if (w >= 0) begin
          eg[w] = 1'b1;
          ptr[b] = (w + 1) % NP;
        end
      end
      for (int li = 0; li < NL; li++) begin
        chk($sformatf("gnt L%0d cyc=%0d", li + 1, cyc), gnt_a[li], eg);
        if (chk_gnt) chk($sformatf("directed_gnt L%0d cyc=%0d", li + 1, cyc), gnt_a[li], want_gnt);
        if (chk_breq) chk($sformatf("directed_bank_req L%0d", li + 1), breq_a[li], want_breq);
      end
      for (int p = 0; p < NP; p++) begin
        if (eg[p]) begin
          idx = bk[p] * 1024 + wd[p];
          e.err  = oor[p];
          e.data = (oor[p] || we[p]) ? '0 : ref_mem[idx];
          for (int li = 0; li < NL; li++) begin
            e.due = cyc + li + 1;
            exp_q[li][p].push_back(e);
          end
          if (we[p] && !oor[p])
            for (int i = 0; i < 16; i++)
              if (be[p][i]) ref_mem[idx][8*i +: 8] = wdata[p][8*i +: 8];
        end
      end
    end
    chk_gnt  = 0;
    chk_breq = 0;
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [127:0] d0, input logic [127:0] d1,
                       input logic [15:0] b0, input logic [15:0] b1);
    rst = r; req = rq; we = w;
    addr[0] = a0; addr[1] = a1;
    wdata[0] = d0; wdata[1] = d1;
    be[0] = b0; be[1] = b1;
    if (r) begin
      for (int li = 0; li < NL; li++)
        for (int p = 0; p < NP; p++) exp_q[li][p].delete();
      for (int b = 0; b < NB; b++) ptr[b] = 0;
    end
    @(negedge clk);
    model(r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
    // Reset with live requests: nothing may be granted or reach a bank.
    drive(1, 2'b11, 2'b00, 32'h10, 32'h50, '0, '0, 16'hFFFF, 16'hFFFF);
    drive(1, 2'b11, 2'b00, 32'h10, 32'h50, '0, '0, 16'hFFFF, 16'hFFFF);
    mem_clr = 1'b0;

    for (int i = 0; i < 4; i++) begin
      chk_gnt = 1; want_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      drive(0, 2'b11, 2'b00, 32'h10, 32'h50, '0, '0, '0, '0);
    end

    chk_gnt = 1; want_gnt = 2'b01;
    drive(0, 2'b01, 2'b01, 32'h0, 32'h0, A5, '0, 16'hFFFF, '0);
    chk_gnt = 1; want_gnt = 2'b01;
    drive(0, 2'b01, 2'b00, 32'h0, 32'h0, '0, '0, '0, '0);

    chk_gnt = 1; want_gnt = 2'b11;
    drive(0, 2'b11, 2'b00, 32'h0, 32'h10, '0, '0, '0, '0);

    chk_gnt = 1; want_gnt = 2'b01; chk_breq = 1; want_breq = 4'b0000;
    drive(0, 2'b01, 2'b00, 32'h0001_0000, 32'h0, '0, '0, '0, '0);

    // Three grants leave bank 1's pointer at port 1, then reset mid-flight.
    drive(0, 2'b11, 2'b00, 32'h10, 32'h50, '0, '0, '0, '0);
    drive(0, 2'b01, 2'b00, 32'h10, 32'h0, '0, '0, '0, '0);
    drive(0, 2'b01, 2'b00, 32'h20, 32'h0, '0, '0, '0, '0);
    drive(1, 2'b00, 2'b00, 32'h0, 32'h0, '0, '0, '0, '0);
    chk_gnt = 1; want_gnt = 2'b01;
    drive(0, 2'b11, 2'b00, 32'h10, 32'h50, '0, '0, '0, '0);
    for (int i = 0; i < 6; i++) drive(0, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] rq, wr;
      logic [31:0] a [NP];
      logic [127:0] d [NP];
      logic [15:0] bb [NP];
      for (int p = 0; p < NP; p++) begin
        rq[p] = ($urandom_range(3) != 0);
        wr[p] = 1'($urandom_range(1));
        a[p] = (32'($urandom_range(3)) << 6) | (32'($urandom_range(3)) << 4) | 32'($urandom_range(15));
        if ($urandom_range(15) == 0) a[p] = a[p] | (32'h1 << $urandom_range(31, 16));
        d[p] = {$urandom, $urandom, $urandom, $urandom};
        bb[p] = 16'($urandom);
      end
      drive(0, rq, wr, a[0], a[1], d[0], d[1], bb[0], bb[1]);
    end

    for (int i = 0; i < 6; i++) drive(0, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    for (int li = 0; li < NL; li++)
      for (int p = 0; p < NP; p++)
        chk($sformatf("outstanding L%0d P%0d", li + 1, p), exp_q[li][p].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_mem_ctrl.md
BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requestor ports (1..8).
REQ-002 SHALL have parameter NUM_BANKS, default 4: number of SRAM banks (power of two, 1..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 128: word width (power of two, >=32).
REQ-005 SHALL have parameter BANK_WORDS, default 1024: words per bank (power of two).
REQ-006 SHALL have parameter RD_LATENCY, default 1: bank read latency in cycles (1..4).
REQ-007 SHALL have one clock and a synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-009 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-010 SHALL have ports req_i, we_i, input, [NUM_PORTS]: request and write enable per port.
REQ-011 SHALL have port addr_i, input, [NUM_PORTS][ADDR_WIDTH]: byte address.
REQ-012 SHALL have ports be_i and wdata_i, input, [NUM_PORTS][DATA_WIDTH/8] and [NUM_PORTS][DATA_WIDTH]: byte enables and write data.
REQ-013 SHALL have port gnt_o, output, [NUM_PORTS]: request accepted this cycle.
REQ-014 SHALL have ports rvalid_o and err_o, output, [NUM_PORTS]: response valid and address error.
REQ-015 SHALL have port rdata_o, output, [NUM_PORTS][DATA_WIDTH]: read data.
REQ-016 SHALL have ports bank_req_o and bank_we_o, output, [NUM_BANKS]: per-bank access and write enable.
REQ-017 SHALL have port bank_addr_o, output, [NUM_BANKS][log2(BANK_WORDS)]: bank word index.
REQ-018 SHALL have ports bank_be_o and bank_wdata_o, output, [NUM_BANKS][DATA_WIDTH/8] and [NUM_BANKS][DATA_WIDTH].
REQ-019 SHALL have port bank_rdata_i, input, [NUM_BANKS][DATA_WIDTH]: valid RD_LATENCY cycles after bank_req_o.

Function
REQ-020 SHALL decode OFF=log2(DATA_WIDTH/8); bank=addr[OFF +: log2(NUM_BANKS)]; word=addr[OFF+log2(NUM_BANKS) +: log2(BANK_WORDS)]; low OFF bits ignored.
REQ-021 SHALL flag an address as out-of-range when any bit at or above OFF+log2(NUM_BANKS)+log2(BANK_WORDS) is set.
REQ-022 SHALL arbitrate each bank independently with round-robin among ports requesting that bank; gnt_o is combinational in the request cycle.
REQ-023 SHALL advance a bank's round-robin pointer to winner+1 (mod NUM_PORTS) only on a grant to that bank; pointer holds otherwise.
REQ-024 SHALL grant out-of-range requests immediately with no bank access.
REQ-025 SHALL drive bank_* from the winning port in the grant cycle; bank_req_o=0 and other bank outputs 0 when no winner.
REQ-026 SHALL assert rvalid_o exactly RD_LATENCY cycles after each grant, for reads and writes alike.
REQ-027 SHALL return bank_rdata_i of the granted bank on rdata_o for in-range reads; rdata_o=0 for writes, errors and idle.
REQ-028 SHALL assert err_o with rvalid_o for out-of-range requests, else err_o=0.
REQ-029 SHALL track in-flight responses with a per-port RD_LATENCY-deep shift register of {valid, bank, we, err}; full throughput of one grant per port per cycle.
REQ-030 SHALL keep responses of each port in issue order; different ports are independent.
REQ-031 SHALL ignore we_i, be_i, wdata_i and addr_i of ports with req_i=0.

Reset
REQ-032 SHALL, while rst=1, clear all round-robin pointers to 0, clear all shift registers, force gnt_o, rvalid_o, err_o, rdata_o and bank_req_o to 0.
REQ-033 SHALL drop in-flight responses when rst is asserted mid-operation; no rvalid_o for them after rst deasserts.

Structure
REQ-034 SHALL place parameter defaults, OFF computation helper and the in-flight entry struct in package banked_mem_pkg.
REQ-035 SHALL instantiate one sub-module rr_arbiter (parametrised by NUM_PORTS, holding its pointer) per bank.

Verification
REQ-036 SHALL test: port0 writes 0xA5.. to addr 0x0, then reads 0x0 -> rvalid_o[0] RD_LATENCY cycles after each grant, read returns 0xA5.., err_o=0.
REQ-037 SHALL test: both ports request bank 1 every cycle for 4 cycles -> grants alternate P0,P1,P0,P1; no cycle grants both.
REQ-038 SHALL test: P0 addr 0x00 (bank0), P1 addr 0x10 (bank1), same cycle -> both granted same cycle, both rvalid_o same later cycle.
REQ-039 SHALL test: read of addr 0x0001_0000 with defaults (limit 64 KiB) -> gnt_o=1, bank_req_o=0, rvalid_o with err_o=1, rdata_o=0.
REQ-040 SHALL test: rst pulsed one cycle after 3 back-to-back grants with RD_LATENCY=4 -> no rvalid_o follows; pointers back to 0.
REQ-041 SHALL test: sweep RD_LATENCY 1..4 with random traffic vs a reference model -> data, order and err_o match.
